// File: rtl/or_nor_checker_pkg.sv
// Shared definitions for the OR/NOR checker family: FSM states, vector count
// and the golden truth-table function.
package or_nor_checker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int unsigned NUM_VECS = 4;

  // Returns {or, nor} for the given gate inputs.
  function automatic logic [1:0] or_nor_expect(input logic in1, input logic in0);
    return {in1 | in0, ~(in1 | in0)};
  endfunction

endpackage

// File: rtl/or_nor_checker_golden.sv
// Combinational OR/NOR truth table, shared by the gate checkers.
module or_nor_golden
  import or_nor_checker_pkg::*;
(
  input  logic in0,
  input  logic in1,
  output logic exp_or,
  output logic exp_nor
);

  always_comb begin
    {exp_or, exp_nor} = or_nor_expect(in1, in0);
  end

endmodule

// File: rtl/or_nor_checker.sv
// Driver+monitor for an OR/NOR gate: sweeps the truth table, counts mismatches.
// Optional first-mismatch capture ports: define OR_NOR_CHECK_FIRST_ERR_EN.
module or_nor_checker
  import or_nor_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             drv_in0,
  output logic             drv_in1,
  input  logic             dut_or,
  input  logic             dut_nor,
  output logic [1:0]       vec_idx,
  output logic [ERR_W-1:0] err_count
`ifdef OR_NOR_CHECK_FIRST_ERR_EN
  ,
  output logic             first_err_vld,
  output logic [1:0]       first_err_vec,
  output logic [1:0]       first_err_obs
`endif
);

  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam int PC_W = $clog2(NUM_PASSES + 1);

  state_t           state;
  logic [SC_W-1:0]  settle_cnt;
  logic [PC_W-1:0]  pass_cnt;
  logic             exp_or;
  logic             exp_nor;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  or_nor_golden u_golden (
    .in0     (drv_in0),
    .in1     (drv_in1),
    .exp_or  (exp_or),
    .exp_nor (exp_nor)
  );

  // Case-inequality so X/Z from the gate counts as a mismatch in simulation.
  always_comb begin
    mismatch = (dut_or !== exp_or) || (dut_nor !== exp_nor);
    err_next = err_count;
    if (mismatch && (err_count != '1)) begin
      err_next = err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      drv_in0    <= 1'b0;
      drv_in1    <= 1'b0;
      vec_idx    <= '0;
      err_count  <= '0;
      settle_cnt <= '0;
      pass_cnt   <= '0;
`ifdef OR_NOR_CHECK_FIRST_ERR_EN
      first_err_vld <= 1'b0;
      first_err_vec <= '0;
      first_err_obs <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SETTLE;
            err_count  <= '0;
            pass       <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            vec_idx    <= '0;
            drv_in0    <= 1'b0;
            drv_in1    <= 1'b0;
            settle_cnt <= '0;
            pass_cnt   <= '0;
`ifdef OR_NOR_CHECK_FIRST_ERR_EN
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
            first_err_obs <= '0;
`endif
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + SC_W'(1);
          if (settle_cnt == SC_W'(SETTLE_CYCLES - 1)) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          err_count  <= err_next;
          settle_cnt <= '0;
`ifdef OR_NOR_CHECK_FIRST_ERR_EN
          if (mismatch && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_vec <= vec_idx;
            first_err_obs <= {dut_or, dut_nor};
          end
`endif
          if (vec_idx != 2'(NUM_VECS - 1)) begin
            vec_idx <= vec_idx + 2'd1;
            {drv_in1, drv_in0} <= vec_idx + 2'd1;
            state   <= SETTLE;
          end else if (pass_cnt != PC_W'(NUM_PASSES - 1)) begin
            pass_cnt <= pass_cnt + PC_W'(1);
            vec_idx  <= '0;
            {drv_in1, drv_in0} <= 2'b00;
            state    <= SETTLE;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or_nor_checker.sv
// Directed bench for or_nor_checker: three instances with differing parameters,
// each facing a behavioural gate with a selectable fault.
module tb_or_nor_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start, busy, done, pass, drv0, drv1, dor, dnor;
  logic [1:0] vec [3];
  logic [1:0] fm [3];
  logic [7:0] err0, err1;
  logic [1:0] err2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // fm: 0 good, 1 or stuck-0, 2 nor follows or, 3 outputs swapped
  function automatic logic [1:0] gate(input logic [1:0] f, input logic a1, input logic a0);
    logic o;
    o = a1 | a0;
    case (f)
      2'd0:    return {o, ~o};
      2'd1:    return {1'b0, ~o};
      2'd2:    return {o, o};
      default: return {~o, o};
    endcase
  endfunction

  assign {dor[0], dnor[0]} = gate(fm[0], drv1[0], drv0[0]);
  assign {dor[1], dnor[1]} = gate(fm[1], drv1[1], drv0[1]);
  assign {dor[2], dnor[2]} = gate(fm[2], drv1[2], drv0[2]);

`ifdef OR_NOR_CHECK_FIRST_ERR_EN
  logic       fe_vld;
  logic [1:0] fe_vec, fe_obs;
`endif

  or_nor_checker u0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .drv_in0(drv0[0]), .drv_in1(drv1[0]), .dut_or(dor[0]),
    .dut_nor(dnor[0]), .vec_idx(vec[0]), .err_count(err0)
`ifdef OR_NOR_CHECK_FIRST_ERR_EN
    , .first_err_vld(fe_vld), .first_err_vec(fe_vec), .first_err_obs(fe_obs)
`endif
  );

  or_nor_checker #(.NUM_PASSES(2)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .drv_in0(drv0[1]), .drv_in1(drv1[1]), .dut_or(dor[1]),
    .dut_nor(dnor[1]), .vec_idx(vec[1]), .err_count(err1)
`ifdef OR_NOR_CHECK_FIRST_ERR_EN
    , .first_err_vld(), .first_err_vec(), .first_err_obs()
`endif
  );

  or_nor_checker #(.NUM_PASSES(2), .ERR_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .drv_in0(drv0[2]), .drv_in1(drv1[2]), .dut_or(dor[2]),
    .dut_nor(dnor[2]), .vec_idx(vec[2]), .err_count(err2)
`ifdef OR_NOR_CHECK_FIRST_ERR_EN
    , .first_err_vld(), .first_err_vec(), .first_err_obs()
`endif
  );

  function automatic logic [31:0] get_err(input int i);
    case (i)
      0:       return {24'd0, err0};
      1:       return {24'd0, err1};
      default: return {30'd0, err2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; lat=0 if the bound expires.
  task automatic wait_done(input int i, input int max, output int lat, output logic [7:0] seq);
    lat = 0;
    seq = '0;
    for (int k = 1; k <= max; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) chk("busy_run", {31'd0, busy[i]}, 32'd1);
      if (k == 1)  seq[1:0] = vec[i];
      if (k == 4)  seq[3:2] = vec[i];
      if (k == 7)  seq[5:4] = vec[i];
      if (k == 10) seq[7:6] = vec[i];
      if (done[i]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_busy"}, {31'd0, busy[0]}, 32'd0);
    chk({tag, "_done"}, {31'd0, done[0]}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass[0]}, 32'd0);
    chk({tag, "_drv"},  {30'd0, drv1[0], drv0[0]}, 32'd0);
    chk({tag, "_vec"},  {30'd0, vec[0]}, 32'd0);
    chk({tag, "_err"},  get_err(0), 32'd0);
  endtask

  initial begin
    int lat;
    logic [7:0] seq;
    rst   = 1'b1;
    start = '0;
    fm[0] = 2'd0; fm[1] = 2'd2; fm[2] = 2'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_idle_reset("reset");

    // Good gate, defaults
    start_run(0);
    wait_done(0, 100, lat, seq);
    chk("t1_latency", lat, 32'd12);
    chk("t1_vec_seq", {24'd0, seq}, 32'h000000e4);
    chk("t1_pass", {31'd0, pass[0]}, 32'd1);
    chk("t1_err", get_err(0), 32'd0);
    chk("t1_busy_end", {31'd0, busy[0]}, 32'd0);

    // or stuck at 0
    fm[0] = 2'd1;
    start_run(0);
    wait_done(0, 100, lat, seq);
    chk("t2_latency", lat, 32'd12);
    chk("t2_pass", {31'd0, pass[0]}, 32'd0);
    chk("t2_err", get_err(0), 32'd3);
`ifdef OR_NOR_CHECK_FIRST_ERR_EN
    chk("t2_fe_vld", {31'd0, fe_vld}, 32'd1);
    chk("t2_fe_vec", {30'd0, fe_vec}, 32'd1);
    chk("t2_fe_obs", {30'd0, fe_obs}, 32'd0);
`endif

    // nor follows or, two passes
    start_run(1);
    wait_done(1, 100, lat, seq);
    chk("t3_latency", lat, 32'd24);
    chk("t3_err", get_err(1), 32'd8);
    chk("t3_pass", {31'd0, pass[1]}, 32'd0);

    // swapped outputs, 2-bit counter saturates
    start_run(2);
    wait_done(2, 100, lat, seq);
    chk("t4_latency", lat, 32'd24);
    chk("t4_err", get_err(2), 32'd3);
    chk("t4_pass", {31'd0, pass[2]}, 32'd0);

    // start held high in DONE restarts on the next edge and clears err_count
    fm[0] = 2'd0;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    chk("t6_restart_busy", {31'd0, busy[0]}, 32'd1);
    chk("t6_restart_done", {31'd0, done[0]}, 32'd0);
    chk("t6_restart_err", get_err(0), 32'd0);
    // start pulsed while busy is ignored
    repeat (4) @(posedge clk);
    #1;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    chk("t6_vec_mid", {30'd0, vec[0]}, 32'd1);
    wait_done(0, 100, lat, seq);
    chk("t6_latency", lat + 5, 32'd12);
    chk("t6_pass", {31'd0, pass[0]}, 32'd1);
    chk("t6_err", get_err(0), 32'd0);

    // rst during SETTLE of vector 2
    start_run(0);
    repeat (7) @(posedge clk);
    #1;
    chk("t5_vec_before", {30'd0, vec[0]}, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle_reset("t5");
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_done", {31'd0, done[0]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
